// File: rtl/rotor_state_gen.sv
// rotor_state_gen: generates the 3-bit rotor position for the display block.
// The en/cw switches are synchronized, optionally debounced, and a prescaler
// advances the position once every TICK_DIV cycles while enabled.
// Optional feature macro: ROTOR_STATE_GEN_DEBOUNCE_EN (switch debounce filter).
module rotor_state_gen #(
    parameter int TICK_DIV  = 50000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       en,
    input  logic       cw,
    output logic [2:0] state,
    output logic       step
);

    // An out-of-range configuration never steps, so the misconfiguration is
    // obvious on the display instead of producing a subtly wrong period.
    localparam bit PARAMS_LEGAL = (TICK_DIV >= 2) && (TICK_DIV <= 2**27) &&
                                  (DB_CYCLES >= 1) && (DB_CYCLES <= 2**24);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic             enMeta_q, enSync_q;
    logic             cwMeta_q, cwSync_q;
    logic             enF, cwF;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       state_q, state_d;
    logic             step_q;
    logic             tick;

    // Two-flop synchronizers bring the asynchronous switches into the clock domain.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            enMeta_q <= 1'b0;
            enSync_q <= 1'b0;
            cwMeta_q <= 1'b0;
            cwSync_q <= 1'b0;
        end else begin
            enMeta_q <= en;
            enSync_q <= enMeta_q;
            cwMeta_q <= cw;
            cwSync_q <= cwMeta_q;
        end
    end

`ifdef ROTOR_STATE_GEN_DEBOUNCE_EN
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] enDbCnt_q, enDbCnt_d;
    logic [DB_W-1:0] cwDbCnt_q, cwDbCnt_d;
    logic            enF_q, enF_d;
    logic            cwF_q, cwF_d;

    // A filtered level flips only after the synchronized input has disagreed
    // with it for DB_CYCLES cycles in a row; any agreement restarts the count.
    always_comb begin
        enF_d     = enF_q;
        enDbCnt_d = '0;
        if (enSync_q != enF_q) begin
            if (enDbCnt_q == DB_MAX) begin
                enF_d = enSync_q;
            end else begin
                enDbCnt_d = enDbCnt_q + DB_W'(1);
            end
        end

        cwF_d     = cwF_q;
        cwDbCnt_d = '0;
        if (cwSync_q != cwF_q) begin
            if (cwDbCnt_q == DB_MAX) begin
                cwF_d = cwSync_q;
            end else begin
                cwDbCnt_d = cwDbCnt_q + DB_W'(1);
            end
        end
    end

    // Debounce counters and filtered levels.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            enDbCnt_q <= '0;
            cwDbCnt_q <= '0;
            enF_q     <= 1'b0;
            cwF_q     <= 1'b0;
        end else begin
            enDbCnt_q <= enDbCnt_d;
            cwDbCnt_q <= cwDbCnt_d;
            enF_q     <= enF_d;
            cwF_q     <= cwF_d;
        end
    end

    assign enF = enF_q;
    assign cwF = cwF_q;
`else
    assign enF = enSync_q;
    assign cwF = cwSync_q;
`endif

    // Prescaler and position update: the counter freezes while disabled, and a
    // tick moves the position one step in the direction seen in that cycle.
    always_comb begin
        tick    = enF && (cnt_q == CNT_MAX) && PARAMS_LEGAL;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (enF) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        end
        if (tick) begin
            state_d = cwF ? state_q + 3'd1 : state_q - 3'd1;
        end
    end

    // Registered position, prescaler and one-cycle step pulse.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cnt_q   <= '0;
            state_q <= 3'd0;
            step_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            step_q  <= tick;
        end
    end

    assign state = state_q;
    assign step  = step_q;

endmodule

// File: doc/rotor_state_gen.md
ROTOR_STATE_GEN -- requirements
Module: rotor_state_gen

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clock cycles per step period (legal range 2..2^27).
REQ-002 SHALL have parameter DB_CYCLES, default 1000000, consecutive stable cycles required to accept a new switch level (legal range 1..2^24).
REQ-003 SHALL have port CLK100MHZ  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port CPU_RESETN  input  1  reset; the design has one clock, and reset is asynchronous and active-low.
REQ-005 SHALL have port en  input  1  asynchronous switch; 1 = rotation running.
REQ-006 SHALL have port cw  input  1  asynchronous switch; 1 = clockwise (increment), 0 = counter-clockwise (decrement).
REQ-007 SHALL have port state  output  3  current rotor position 0..7, consumed by the seven-segment display block.
REQ-008 SHALL have port step  output  1  single-cycle pulse, high in the cycle in which state holds its new value.

Function
REQ-009 en and cw SHALL each pass through a two-flop synchronizer before any other use.
REQ-010 Filtered values en_f and cw_f SHALL come from the synchronizer outputs, filtered as set under Configuration.
REQ-011 Prescaler: a counter SHALL count 0..TICK_DIV-1 while en_f=1 and SHALL assert an internal tick on the cycle it equals TICK_DIV-1, then wrap to 0.
REQ-012 While en_f=0, the prescaler SHALL hold its value, tick SHALL be 0, and state SHALL hold.
REQ-013 On tick with cw_f=1, state SHALL go to (state+1) mod 8, so 7 wraps to 0.
REQ-014 On tick with cw_f=0, state SHALL go to (state-1) mod 8, so 0 wraps to 7.
REQ-015 state SHALL update on the clock edge that ends the tick cycle.
REQ-016 step SHALL be registered and high for exactly the one cycle after that edge; otherwise step SHALL be 0.
REQ-017 Simultaneous events: a change of cw_f in the tick cycle SHALL take effect for that tick (the registered cw_f value present in the tick cycle is used).
REQ-018 Simultaneous events: en_f falling in the tick cycle SHALL suppress that tick.
REQ-019 Successive steps SHALL be exactly TICK_DIV cycles apart while en_f stays 1.
REQ-020 On en_f rising again, counting SHALL resume from the held prescaler value.
REQ-021 state SHALL never take a value outside 0..7, and step SHALL never be high for two consecutive cycles when TICK_DIV>=2.

Reset
REQ-022 CPU_RESETN=0 SHALL immediately and asynchronously force: state=000, step=0, prescaler=0, synchronizer flops=0, en_f=0, cw_f=0, debounce counters=0.
REQ-023 Reset asserted mid-period or mid-debounce SHALL discard all progress.
REQ-024 Reset release SHALL be sampled on a clock edge, and the first tick SHALL occur no earlier than TICK_DIV cycles after en_f first becomes 1.

Configuration
REQ-025 Macro ROTOR_STATE_GEN_DEBOUNCE_EN defined: each synchronized input SHALL update its filtered value only after the input differs from the filtered value for DB_CYCLES consecutive cycles.
REQ-026 With ROTOR_STATE_GEN_DEBOUNCE_EN defined: a glitch shorter than DB_CYCLES SHALL reset the input's counter to 0 and SHALL leave the filtered value unchanged.
REQ-027 Macro ROTOR_STATE_GEN_DEBOUNCE_EN undefined: the filtered values SHALL equal the synchronizer outputs, DB_CYCLES SHALL be ignored, and no debounce counters SHALL be built.

Verification (TICK_DIV=4, DB_CYCLES=3 unless noted)
REQ-028 Reset wrap: hold en=1, cw=1 steadily after reset; the bench SHALL see state 0,1,...,7,0 with one-cycle step pulses exactly 4 cycles apart.
REQ-029 CCW wrap: from state=0, set cw=0 with en=1; the next step SHALL give state=7, then 6.
REQ-030 Pause/resume: drop en for 20 cycles mid-period; state SHALL hold, and after en returns the next step SHALL arrive after the remaining period count only.
REQ-031 Glitch rejection (debounce macro defined): a 2-cycle pulse on cw SHALL cause no direction change, while a 3-cycle-stable change SHALL be accepted.
REQ-032 Glitch rejection (debounce macro undefined): a 1-cycle pulse on cw SHALL propagate after 2 sync cycles.
REQ-033 Async reset: assert CPU_RESETN=0 between clock edges at state=5; state SHALL read 0 and step SHALL read 0 before the next edge.
